// File: rtl/fft_peak_finder.sv
// Streams FFT bins through a squared-magnitude pipeline and reports the strongest
// positive-frequency bin (DC and mirrored half excluded) once per frame.
module fft_peak_finder #(
    parameter int bit_width = 16,
    parameter int M         = 9,
    parameter int MIN_BIN   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [2*bit_width-1:0] in_data,
    input  logic [2*bit_width-1:0] thresh,
    output logic                   busy,
    output logic                   done,
    output logic                   peak_valid,
    output logic [M-1:0]           peak_bin,
    output logic [2*bit_width-1:0] peak_mag
);

    localparam int W2 = 2 * bit_width;
    localparam logic [M-1:0] LAST_TAG = {M{1'b1}};
    localparam logic [M-1:0] MIN_TAG  = M'(MIN_BIN);
    localparam logic [M-1:0] HALF_MAX = {1'b0, {(M-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    // Handshake: a bin is taken on any posedge where in_valid=1, state is SCAN
    // and start is low; there is no backpressure, so gaps simply stall the count.
    state_t state, next_state;

    logic [M-1:0]  cnt;
    logic [W2-1:0] thr_q;
    logic          accept;

    logic                        s0_v, s0_last;
    logic [M-1:0]                s0_tag;
    logic signed [bit_width-1:0] s0_re, s0_im;
    logic signed [W2-1:0]        prod_re, prod_im;

    logic          s1_v, s1_last;
    logic [M-1:0]  s1_tag;
    logic [W2-2:0] s1_p_re, s1_p_im;

    logic          s2_v, s2_last;
    logic [M-1:0]  s2_tag;
    logic [W2-1:0] s2_mag;
    logic          eligible;

    logic [W2-1:0] best_mag;
    logic [M-1:0]  best_bin;
    logic          fin;

    assign accept   = (state == SCAN) && in_valid && !start;
    assign prod_re  = s0_re * s0_re;
    assign prod_im  = s0_im * s0_im;
    assign eligible = (s2_tag >= MIN_TAG) && (s2_tag <= HALF_MAX);

    assign busy = (state == SCAN) || (state == FLUSH);
    assign done = (state == DONE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = SCAN;
            SCAN: begin
                if (start)                          next_state = SCAN;
                else if (accept && cnt == LAST_TAG) next_state = FLUSH;
            end
            FLUSH: begin
                if (start)    next_state = SCAN;
                else if (fin) next_state = DONE;
            end
            DONE:  next_state = start ? SCAN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            thr_q      <= '0;
            s0_v       <= 1'b0;
            s0_last    <= 1'b0;
            s0_tag     <= '0;
            s0_re      <= '0;
            s0_im      <= '0;
            s1_v       <= 1'b0;
            s1_last    <= 1'b0;
            s1_tag     <= '0;
            s1_p_re    <= '0;
            s1_p_im    <= '0;
            s2_v       <= 1'b0;
            s2_last    <= 1'b0;
            s2_tag     <= '0;
            s2_mag     <= '0;
            best_mag   <= '0;
            best_bin   <= '0;
            fin        <= 1'b0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                // Arming (or aborting) discards everything in flight.
                cnt      <= '0;
                thr_q    <= thresh;
                best_mag <= '0;
                best_bin <= MIN_TAG;
                s0_v     <= 1'b0;
                s1_v     <= 1'b0;
                s2_v     <= 1'b0;
                fin      <= 1'b0;
            end else begin
                s0_v    <= accept;
                s0_last <= accept && (cnt == LAST_TAG);
                s0_tag  <= cnt;
                s0_re   <= in_data[W2-1:bit_width];
                s0_im   <= in_data[bit_width-1:0];
                if (accept) cnt <= cnt + 1'b1;

                s1_v    <= s0_v;
                s1_last <= s0_last;
                s1_tag  <= s0_tag;
                s1_p_re <= prod_re[W2-2:0];
                s1_p_im <= prod_im[W2-2:0];

                s2_v    <= s1_v;
                s2_last <= s1_last;
                s2_tag  <= s1_tag;
                s2_mag  <= {1'b0, s1_p_re} + {1'b0, s1_p_im};

                fin <= s2_v && s2_last;
                // Strict compare keeps the earliest (lowest) bin on ties.
                if (s2_v && eligible && (s2_mag > best_mag)) begin
                    best_mag <= s2_mag;
                    best_bin <= s2_tag;
                end
            end
            if (state == FLUSH && fin && !start) begin
                peak_bin   <= best_bin;
                peak_mag   <= best_mag;
                peak_valid <= (best_mag > thr_q);
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed-frame bench for fft_peak_finder: each frame pushes its expected result,
// and a negedge monitor checks every done pulse against the queue.
module tb_fft_peak_finder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] thresh;
    logic        busy;
    logic        done;
    logic        peak_valid;
    logic [8:0]  peak_bin;
    logic [31:0] peak_mag;

    fft_peak_finder #(.bit_width(16), .M(9), .MIN_BIN(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .thresh     (thresh),
        .busy       (busy),
        .done       (done),
        .peak_valid (peak_valid),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic        vld;
        logic [8:0]  bin;
        logic [31:0] mag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] frame[512];
    int          cyc = 0;
    int          last_acc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding frame result.
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("peak_bin",   64'(peak_bin),   64'(e.bin));
                check("peak_mag",   64'(peak_mag),   64'(e.mag));
                check("peak_valid", 64'(peak_valid), 64'(e.vld));
                check("done_cycle", 64'(cyc),        64'(e.cyc));
                check("busy_at_done", 64'(busy),     64'd0);
            end
        end
    end

    task automatic clear_frame();
        for (int i = 0; i < 512; i++) frame[i] = 32'd0;
    endtask

    task automatic pulse_start(input logic [31:0] th);
        start    = 1'b1;
        in_valid = 1'b0;
        thresh   = th;
        @(negedge clk);
        start    = 1'b0;
        thresh   = 32'hDEAD_BEEF;
    endtask

    task automatic send_frame(input int n, input bit gaps);
        int  k  = 0;
        bit  ph = 1'b0;
        while (k < n) begin
            if (gaps && ph) begin
                in_valid = 1'b0;
                in_data  = 32'hFFFF_FFFF;
            end else begin
                in_valid = 1'b1;
                in_data  = frame[k];
                last_acc = cyc + 1;
                k++;
            end
            ph = ~ph;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run(input logic [31:0] th, input bit gaps,
                       input int bin, input logic [31:0] mag, input bit vld);
        exp_t e;
        pulse_start(th);
        send_frame(512, gaps);
        e.cyc = 32'(last_acc + 4);
        e.vld = vld;
        e.bin = 9'(bin);
        e.mag = mag;
        exp_q.push_back(e);
        wait_drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        thresh   = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_done",       64'(done),       64'd0);
        check("rst_peak_valid", 64'(peak_valid), 64'd0);
        check("rst_peak_bin",   64'(peak_bin),   64'd0);
        check("rst_peak_mag",   64'(peak_mag),   64'd0);
        reset = 1'b1;
        @(negedge clk);

        clear_frame(); frame[37] = {16'd1000, 16'd0};
        run(32'd0, 1'b0, 37, 32'd1000000, 1'b1);

        clear_frame(); frame[10] = {16'd300, 16'hFE70}; frame[20] = {16'd300, 16'hFE70};
        run(32'd0, 1'b0, 10, 32'd250000, 1'b1);

        clear_frame();
        frame[0] = {16'd32767, 16'd0}; frame[300] = {16'd20000, 16'd20000}; frame[5] = {16'd3, 16'd4};
        run(32'd0, 1'b0, 5, 32'd25, 1'b1);

        clear_frame(); frame[100] = {16'h8000, 16'h8000};
        run(32'h7FFF_FFFF, 1'b0, 100, 32'h8000_0000, 1'b1);
        run(32'h8000_0000, 1'b0, 100, 32'h8000_0000, 1'b0);

        clear_frame(); frame[255] = {16'd50, 16'd0};
        run(32'd0, 1'b1, 255, 32'd2500, 1'b1);

        clear_frame();
        run(32'd0, 1'b0, 1, 32'd0, 1'b0);

        clear_frame(); frame[37] = {16'd1000, 16'd0};
        run(32'd0, 1'b0, 37, 32'd1000000, 1'b1);
        clear_frame(); frame[64] = {16'd0, 16'd7};
        pulse_start(32'd0);
        send_frame(200, 1'b0);
        pulse_start(32'd0);
        check("abort_hold_bin", 64'(peak_bin), 64'd37);
        check("abort_hold_mag", 64'(peak_mag), 64'd1000000);
        begin
            exp_t e;
            send_frame(512, 1'b0);
            e.cyc = 32'(last_acc + 4);
            e.vld = 1'b1;
            e.bin = 9'd64;
            e.mag = 32'd49;
            exp_q.push_back(e);
            wait_drain();
        end

        pulse_start(32'd0);
        send_frame(100, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",       64'(busy),       64'd0);
        check("mid_rst_done",       64'(done),       64'd0);
        check("mid_rst_peak_valid", 64'(peak_valid), 64'd0);
        check("mid_rst_peak_bin",   64'(peak_bin),   64'd0);
        check("mid_rst_peak_mag",   64'(peak_mag),   64'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_reset", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
